// File: rtl/pipe_s_wallace_mul.sv
// Three-stage pipelined Wallace-tree multiplier with per-beat signed (Baugh-Wooley)
// or unsigned mode, an opaque tag riding along, and valid/ready backpressure on every stage.
module pipe_s_wallace_mul #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 1;

  function automatic int next_rows(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int tree_levels();
    int n;
    int l;
    n = NR;
    l = 0;
    while (n > 2) begin
      n = next_rows(n);
      l++;
    end
    return l;
  endfunction

  localparam int NLEV = tree_levels();
  // Baugh-Wooley correction ones at columns WIDTH and 2*WIDTH-1
  localparam logic [PW-1:0] SGN_ONES = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  logic                          w_rdy1, w_rdy2, w_rdy3;
  logic [WIDTH-1:0][WIDTH-1:0]   w_pp;
  logic [WIDTH-1:0][WIDTH-1:0]   r1_pp;
  logic                          r1_sgn, r1_vld;
  logic [TAG_W-1:0]              r1_tag;
  logic [PW-1:0]                 r2_s, r2_c;
  logic                          r2_vld;
  logic [TAG_W-1:0]              r2_tag;
  logic [PW-1:0]                 r3_p;
  logic                          r3_vld;
  logic [TAG_W-1:0]              r3_tag;

  assign w_rdy3   = !r3_vld || out_ready;
  assign w_rdy2   = !r2_vld || w_rdy3;
  assign w_rdy1   = !r1_vld || w_rdy2;
  assign in_ready = w_rdy1;

  // Row gj holds a[gi]&b[gj]; terms with exactly one MSB index are inverted in signed mode
  generate
    for (genvar gj = 0; gj < WIDTH; gj++) begin : g_row
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        localparam bit EDGE_TERM = (gi == WIDTH - 1) != (gj == WIDTH - 1);
        assign w_pp[gj][gi] = (in_a[gi] & in_b[gj]) ^ (in_signed & EDGE_TERM);
      end
    end
  endgenerate

  logic [PW-1:0] w_tree [NR];
  logic [PW-1:0] w_next [NR];
  int            w_nrows;

  // Parallel 3:2 compressor layers until only a sum row and a carry row remain
  always_comb begin
    w_tree  = '{default: '0};
    w_next  = '{default: '0};
    w_nrows = NR;
    for (int j = 0; j < WIDTH; j++) begin
      w_tree[j] = PW'(r1_pp[j]) << j;
    end
    w_tree[WIDTH] = r1_sgn ? SGN_ONES : '0;
    for (int l = 0; l < NLEV; l++) begin
      w_next = '{default: '0};
      for (int k = 0; k < NR / 3; k++) begin
        if (k < w_nrows / 3) begin
          w_next[2*k]   = w_tree[3*k] ^ w_tree[3*k+1] ^ w_tree[3*k+2];
          w_next[2*k+1] = ((w_tree[3*k] & w_tree[3*k+1]) |
                           (w_tree[3*k] & w_tree[3*k+2]) |
                           (w_tree[3*k+1] & w_tree[3*k+2])) << 1;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (r < w_nrows % 3) begin
          w_next[2*(w_nrows/3)+r] = w_tree[3*(w_nrows/3)+r];
        end
      end
      w_tree  = w_next;
      w_nrows = next_rows(w_nrows);
    end
  end

  logic [PW-2:0] w_g;
  logic [PW-1:0] w_p, w_c, w_sum;

  assign w_g    = r2_s[PW-2:0] & r2_c[PW-2:0];
  assign w_p    = r2_s ^ r2_c;
  assign w_c[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < PW - 1; gi++) begin : g_rca
      assign w_c[gi+1] = w_g[gi] | (w_p[gi] & w_c[gi]);
    end
  endgenerate
  assign w_sum = w_p ^ w_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_pp  <= '0;
      r1_sgn <= 1'b0;
      r1_tag <= '0;
      r1_vld <= 1'b0;
      r2_s   <= '0;
      r2_c   <= '0;
      r2_tag <= '0;
      r2_vld <= 1'b0;
      r3_p   <= '0;
      r3_tag <= '0;
      r3_vld <= 1'b0;
    end else begin
      if (w_rdy1) r1_vld <= in_valid;
      if (in_valid && w_rdy1) begin
        r1_pp  <= w_pp;
        r1_sgn <= in_signed;
        r1_tag <= in_tag;
      end
      if (w_rdy2) r2_vld <= r1_vld;
      if (r1_vld && w_rdy2) begin
        r2_s   <= w_tree[0];
        r2_c   <= w_tree[1];
        r2_tag <= r1_tag;
      end
      if (w_rdy3) r3_vld <= r2_vld;
      if (r2_vld && w_rdy3) begin
        r3_p   <= w_sum;
        r3_tag <= r2_tag;
      end
    end
  end

  assign out_valid = r3_vld;
  assign out_p     = r3_p;
  assign out_tag   = r3_tag;

endmodule

// File: tb/tb_pipe_s_wallace_mul.sv
// Bench for pipe_s_wallace_mul: directed corners/backpressure/reset on WIDTH=8, then
// random valid/ready traffic on WIDTH=8, 4 and 13 against an a*b scoreboard.
module tb_pipe_s_wallace_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  bit         rand_go = 1'b0;
  logic       d_valid = 1'b0;
  logic       d_signed = 1'b0;
  logic       d_ready = 1'b1;
  logic [7:0] d_a = '0;
  logic [7:0] d_b = '0;
  logic [3:0] d_tag = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_w
      localparam int W = (gi == 0) ? 8 : ((gi == 1) ? 4 : 13);

      logic           in_valid, in_ready, in_signed, out_valid, out_ready;
      logic [W-1:0]   in_a, in_b;
      logic [3:0]     in_tag, out_tag;
      logic [2*W-1:0] out_p;

      logic         r_valid = 1'b0;
      logic         r_signed = 1'b0;
      logic         r_ready = 1'b1;
      logic [W-1:0] r_a = '0;
      logic [W-1:0] r_b = '0;
      logic [3:0]   r_tag = '0;
      bit           done = 1'b0;
      int           n_out = 0;

      logic [2*W-1:0] q_p [$];
      logic [3:0]     q_tag [$];

      assign in_valid  = rand_go ? r_valid  : ((gi == 0) && d_valid);
      assign in_signed = rand_go ? r_signed : d_signed;
      assign in_a      = rand_go ? r_a      : W'(d_a);
      assign in_b      = rand_go ? r_b      : W'(d_b);
      assign in_tag    = rand_go ? r_tag    : d_tag;
      assign out_ready = rand_go ? r_ready  : ((gi == 0) ? d_ready : 1'b1);

      pipe_s_wallace_mul #(.WIDTH(W), .TAG_W(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_signed(in_signed),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p    (out_p),
        .out_tag  (out_tag)
      );

      function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
          0:       v = '0;
          1:       v = '1;
          2:       v = {1'b1, {(W-1){1'b0}}};
          3:       v = {1'b0, {(W-1){1'b1}}};
          default: v = W'($urandom);
        endcase
        return v;
      endfunction

      // Scoreboard: exact product of the accepted operands, checked in order on every drain
      initial begin
        logic           stall;
        logic [2*W-1:0] hold_p;
        logic [3:0]     hold_tag;
        longint         sa, sb;
        stall = 1'b0;
        hold_p = '0;
        hold_tag = '0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            q_p.delete();
            q_tag.delete();
            stall = 1'b0;
          end else begin
            if (stall) begin
              check($sformatf("w%0d_hold_valid", W), 64'(out_valid), 64'd1);
              check($sformatf("w%0d_hold_p", W), 64'(out_p), 64'(hold_p));
              check($sformatf("w%0d_hold_tag", W), 64'(out_tag), 64'(hold_tag));
            end
            if (out_valid && out_ready) begin
              if (q_p.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL w%0d_spurious_out: got p=0x%0h tag=%0d required no result", W, out_p, out_tag);
              end else begin
                check($sformatf("w%0d_out_p", W), 64'(out_p), 64'(q_p.pop_front()));
                check($sformatf("w%0d_out_tag", W), 64'(out_tag), 64'(q_tag.pop_front()));
              end
              n_out++;
            end
            if (in_valid && in_ready) begin
              if (in_signed) begin
                sa = longint'($signed(in_a));
                sb = longint'($signed(in_b));
              end else begin
                sa = longint'(in_a);
                sb = longint'(in_b);
              end
              q_p.push_back((2*W)'(sa * sb));
              q_tag.push_back(in_tag);
            end
            stall    = out_valid && !out_ready;
            hold_p   = out_p;
            hold_tag = out_tag;
          end
        end
      end

      initial begin
        wait (rand_go);
        for (int c = 0; c < 800; c++) begin
          @(posedge clk);
          #1;
          r_valid  = ($urandom_range(0, 3) != 0);
          r_ready  = ($urandom_range(0, 3) != 0);
          r_signed = 1'($urandom_range(0, 1));
          r_a      = pick();
          r_b      = pick();
          r_tag    = 4'($urandom);
        end
        @(posedge clk);
        #1;
        r_valid = 1'b0;
        r_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check($sformatf("w%0d_drained", W), 64'(q_p.size()), 64'd0);
        done = 1'b1;
      end
    end
  endgenerate

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [3:0] tag);
    bit ok;
    ok = 1'b0;
    d_a = a;
    d_b = b;
    d_signed = s;
    d_tag = tag;
    d_valid = 1'b1;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      ok = g_w[0].in_ready;
      @(posedge clk);
      #1;
    end
    d_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 30 cycles required accept of tag %0d", tag);
    end
  endtask

  task automatic corner(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [3:0] tag, input logic [15:0] exp);
    sync();
    send(a, b, s, tag);
    @(negedge clk);
    @(negedge clk);
    check($sformatf("lat_early_t%0d", tag), 64'(g_w[0].out_valid), 64'd0);
    @(negedge clk);
    check($sformatf("lat_valid_t%0d", tag), 64'(g_w[0].out_valid), 64'd1);
    check($sformatf("corner_p_t%0d", tag), 64'(g_w[0].out_p), 64'(exp));
    check($sformatf("corner_tag_t%0d", tag), 64'(g_w[0].out_tag), 64'(tag));
  endtask

  initial begin
    int n0;
    logic [15:0] hold;
    bit all_done;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(g_w[0].out_valid), 64'd0);
    check("rst_out_p", 64'(g_w[0].out_p), 64'd0);
    check("rst_out_tag", 64'(g_w[0].out_tag), 64'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(g_w[0].in_ready), 64'd1);

    corner(8'h80, 8'h80, 1'b1, 4'd1, 16'h4000);
    corner(8'h80, 8'h7F, 1'b1, 4'd2, 16'hC080);
    corner(8'hFF, 8'hFF, 1'b1, 4'd3, 16'h0001);
    corner(8'h00, 8'hB3, 1'b1, 4'd4, 16'h0000);
    corner(8'hFF, 8'hFF, 1'b0, 4'd5, 16'hFE01);
    corner(8'hFF, 8'h01, 1'b0, 4'd6, 16'h00FF);

    // Same operand bits, opposite modes, back to back
    sync();
    send(8'hFF, 8'hFF, 1'b0, 4'd7);
    send(8'hFF, 8'hFF, 1'b1, 4'd8);
    @(negedge clk);
    @(negedge clk);
    check("b2b_unsigned_p", 64'(g_w[0].out_p), 64'h0000_0000_0000_FE01);
    check("b2b_unsigned_tag", 64'(g_w[0].out_tag), 64'd7);
    @(negedge clk);
    check("b2b_signed_p", 64'(g_w[0].out_p), 64'h0000_0000_0000_0001);
    check("b2b_signed_tag", 64'(g_w[0].out_tag), 64'd8);

    // Backpressure: six tagged beats into a stalled output
    sync();
    n0 = g_w[0].n_out;
    d_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(8'(k * 37 + 3), 8'(k * 91 + 5), 1'(k % 2), 4'(k));
    @(negedge clk);
    check("bp_full_in_ready", 64'(g_w[0].in_ready), 64'd0);
    check("bp_head_tag", 64'(g_w[0].out_tag), 64'd0);
    hold = g_w[0].out_p;
    check("bp_head_p", 64'(hold), 64'd15);
    d_a = 8'(3 * 37 + 3);
    d_b = 8'(3 * 91 + 5);
    d_signed = 1'b1;
    d_tag = 4'd3;
    d_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_stall_in_ready", 64'(g_w[0].in_ready), 64'd0);
      check("bp_stall_p", 64'(g_w[0].out_p), 64'(hold));
      check("bp_stall_tag", 64'(g_w[0].out_tag), 64'd0);
    end
    sync();
    d_ready = 1'b1;
    for (int k = 3; k < 6; k++) send(8'(k * 37 + 3), 8'(k * 91 + 5), 1'(k % 2), 4'(k));
    repeat (6) sync();
    check("bp_result_count", 64'(g_w[0].n_out - n0), 64'd6);

    // Bubble collapse behind one stalled result
    sync();
    n0 = g_w[0].n_out;
    d_ready = 1'b0;
    send(8'd12, 8'd11, 1'b0, 4'd9);
    repeat (4) @(negedge clk);
    check("bubble_out_valid", 64'(g_w[0].out_valid), 64'd1);
    check("bubble_in_ready", 64'(g_w[0].in_ready), 64'd1);
    check("bubble_head_p", 64'(g_w[0].out_p), 64'd132);
    sync();
    send(8'hF6, 8'd7, 1'b1, 4'd10);
    send(8'd200, 8'd3, 1'b0, 4'd11);
    @(negedge clk);
    check("bubble_full_in_ready", 64'(g_w[0].in_ready), 64'd0);
    check("bubble_head_tag", 64'(g_w[0].out_tag), 64'd9);
    sync();
    d_ready = 1'b1;
    repeat (5) sync();
    check("bubble_result_count", 64'(g_w[0].n_out - n0), 64'd3);

    // Asynchronous reset with three beats in flight
    sync();
    send(8'd5, 8'd6, 1'b0, 4'd12);
    send(8'd7, 8'd8, 1'b0, 4'd13);
    send(8'd9, 8'd10, 1'b0, 4'd14);
    n0 = g_w[0].n_out;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(g_w[0].out_valid), 64'd0);
    check("midrst_out_p", 64'(g_w[0].out_p), 64'd0);
    check("midrst_out_tag", 64'(g_w[0].out_tag), 64'd0);
    @(negedge clk);
    sync();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("postrst_idle", 64'(g_w[0].out_valid), 64'd0);
    end
    check("postrst_no_stale", 64'(g_w[0].n_out - n0), 64'd0);

    sync();
    rand_go = 1'b1;
    all_done = 1'b0;
    for (int k = 0; k < 3000 && !all_done; k++) begin
      @(posedge clk);
      all_done = g_w[0].done && g_w[1].done && g_w[2].done;
    end
    if (!all_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL random_timeout: got unfinished regression required completion within 3000 cycles");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_s_wallace_mul.md
Name: pipe_s_wallace_mul

Overview:
- Parametrised, pipelined Wallace-tree multiplier. Successor to the flat combinational Wallace/PG-RCA multipliers.
- Generalised from fixed 4 bit to WIDTH bits, with a per-transaction signed/unsigned mode.
- Signed mode uses Baugh-Wooley partial products.
- Three register stages with valid/ready handshake and full backpressure; throughput one product per cycle.
- Sits between operand producers and accumulate/datapath consumers in arithmetic pipelines.

Parameters:
- WIDTH, 8, operand width in bits (>=4); product is 2*WIDTH bits.
- TAG_W, 4, width of the opaque tag carried alongside each operation (>=1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_tag  input  TAG_W  user tag, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts a result.
- out_p  output  2*WIDTH  product.
- out_tag  output  TAG_W  tag of that product.

Behaviour:
- Reset is asynchronous on rst_n low. All stage valid flags clear and all data registers go to 0.
  - Outputs in reset: out_valid=0, out_p=0, out_tag=0.
  - in_ready=1 once rst_n is high (pipeline empty).
- Reset mid-operation discards every in-flight beat. No result for those beats is ever produced.
- Stage S1 (register 1) holds the partial-product matrix.
  - Partial product = a[i]&b[j].
  - When in_signed=1: invert terms with exactly one index = WIDTH-1, and inject constant 1s at columns WIDTH and 2*WIDTH-1.
- Stage S2 (register 2) performs Wallace reduction with half/full adders down to two rows of 2*WIDTH bits. Only the two rows are registered.
- Stage S3 (register 3) sums the two rows with a propagate/generate ripple-carry adder. The result is truncated to 2*WIDTH bits and drives out_p.
- The mode and tag travel with their operands through every stage. Beats do not interact.
- Latency is exactly 3 cycles from the accept edge (in_valid&&in_ready) to out_valid, when out_ready stays high.
- Per-stage handshake:
  - ready_k = !valid_k || ready_{k+1}, with ready_4 = out_ready; in_ready = ready_1.
  - Stage k loads when valid_{k-1} && ready_k; valid_k holds when !ready_{k+1}.
  - in_ready may combinationally depend on out_ready. No combinational path from in_* data to out_*.
- Bubbles collapse: a stalled output does not block the filling of empty upstream stages.
- At most 3 beats are in flight. When full and out_ready=0, in_ready=0.
- While out_valid=1 && out_ready=0, out_p and out_tag hold stable.
- Simultaneous accept at the input and drain at the output in the same cycle is allowed; the full pipeline sustains 1 beat/cycle.
- Arithmetic is exact for all operand pairs in both modes. There is no overflow, since the 2*WIDTH product fits.
  - Signed (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
- in_a/in_b/in_signed/in_tag are don't-care when in_valid=0.

Test Plan:
- Signed corners, WIDTH=8, out_ready=1:
  - (-128,-128) -> 0x4000 at cycle+3.
  - (-128,127) -> 0xC080.
  - (-1,-1) -> 0x0001.
  - (0,-77) -> 0x0000.
- Unsigned corners:
  - 255*255 -> 0xFE01.
  - 255*1 -> 0x00FF.
  - The same bits 0xFF*0xFF with in_signed=1 -> 0x0001, issued back-to-back with the unsigned case, proving per-beat mode.
- Backpressure:
  - Stream 6 beats with tags 0..5 while out_ready=0 for 5 cycles.
  - Required: in_ready drops after 3 accepts; out_p/out_tag stay stable.
  - On release, results emerge in order with tags 0..5, none lost or duplicated.
- Bubble collapse: one beat stalled at the output, then two more beats issued. Both are accepted and fill S2/S1 with no drop.
- Reset mid-stream: pulse rst_n low with 3 beats in flight. Required: out_valid=0 and out_p=0 immediately (asynchronously), and no stale result appears after release.
- Random regression at WIDTH=4, 8 and 13: random valid/ready and mode, with results compared against a behavioural a*b model. All results are exact and in order.
